// File: rtl/alu_arb_pkg.sv
// ============================================================================
// alu_arb_pkg : shared types and constants for the two-port ALU arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    localparam int DATA_W_DFLT = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2  : two-way round-robin pick; on contention the side not granted last wins
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    assign grant_valid = |valid;
    assign grant       = valid[1] & (~valid[0] | ~last_grant);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : shares one external combinational ALU between two requesters.
//               Optional ALU_ARB_ZERO_FLAG_EN adds a registered resp_zero output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    output logic              busy
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic              resp_zero
`endif
);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant, grant_valid;
    logic              accept;
    logic [2:0]        lat_op;
    logic [DATA_W-1:0] lat_a, lat_b;
    logic              lat_id;

    rr_arb2 u_rr_arb2 (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_f      = 3'b000;
        case (state)
            IDLE: begin
                req0_ready = grant_valid & ~grant;
                req1_ready = grant_valid &  grant;
                if (grant_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_a     = lat_a;
                alu_b     = lat_b;
                alu_f     = lat_op;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_valid && resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            lat_op     <= 3'b000;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                lat_id     <= grant;
                lat_op     <= grant ? req1_op : req0_op;
                lat_a      <= grant ? req1_a  : req0_a;
                lat_b      <= grant ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                resp_data <= alu_y;
                resp_id   <= lat_id;
            end
            // RESP opens with one cycle of resp_valid low before the result is offered
            if (state == RESP) begin
                if (!resp_valid)     resp_valid <= 1'b1;
                else if (resp_ready) resp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              resp_zero <= 1'b0;
        else if (state == EXEC)  resp_zero <= (alu_y == '0);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed table-driven bench for alu_arbiter with a behavioural ALU
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_f;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [15:0] resp_data, alu_a, alu_b, alu_y;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic        resp_zero;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_y      (alu_y),
        .busy       (busy)
`ifdef ALU_ARB_ZERO_FLAG_EN
        ,
        .resp_zero  (resp_zero)
`endif
    );

    // External ALU; unknown codes pass operand a through
    always_comb begin
        case (alu_f)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b011:  alu_y = alu_a ^ alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            default: alu_y = alu_a;
        endcase
    end

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic id, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic check_zero(input string name, input logic [15:0] exp);
`ifdef ALU_ARB_ZERO_FLAG_EN
        check(name, 16'(resp_zero), 16'(exp == 16'h0000));
`else
        if (exp == 16'hFFFF) $display("%s", name);
`endif
    endtask

    // Waits (bounded) for resp_valid, then checks the offered result
    task automatic wait_resp(input string name, input logic [15:0] exp, input logic id);
        int k;
        k = 0;
        while (!resp_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_timeout"}, 16'(resp_valid), 16'd1);
        check({name, "_data"}, resp_data, exp);
        check({name, "_id"}, 16'(resp_id), 16'(id));
        check_zero({name, "_zero"}, exp);
    endtask

    task automatic run_single(input vec_t v, input string name);
        @(negedge clk);
        drive(v.id, 1'b1, v.op, v.a, v.b);
        resp_ready = 1'b1;
        #1;
        check({name, "_rdy_own"},   16'(v.id ? req1_ready : req0_ready), 16'd1);
        check({name, "_rdy_other"}, 16'(v.id ? req0_ready : req1_ready), 16'd0);
        @(posedge clk); #1;
        drive(v.id, 1'b0, 3'b101, 16'hDEAD, 16'hBEEF);
        check({name, "_exec_busy"}, 16'(busy), 16'd1);
        check({name, "_exec_f"}, 16'(alu_f), 16'(v.op));
        check({name, "_exec_a"}, alu_a, v.a);
        check({name, "_exec_b"}, alu_b, v.b);
        @(posedge clk); #1;
        check({name, "_resp0_valid"}, 16'(resp_valid), 16'd0);
        check({name, "_resp0_alu_f"}, 16'(alu_f), 16'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 16'(resp_valid), 16'd1);
        check({name, "_data"}, resp_data, v.exp);
        check({name, "_id"}, 16'(resp_id), 16'(v.id));
        check_zero({name, "_zero"}, v.exp);
        @(posedge clk); #1;
        check({name, "_done_valid"}, 16'(resp_valid), 16'd0);
        check({name, "_done_busy"}, 16'(busy), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 3'b010, 16'h0003, 16'h0004, 16'h0007};
        vecs[1] = '{1'b1, 3'b110, 16'h0005, 16'h0007, 16'hFFFE};
        vecs[2] = '{1'b0, 3'b001, 16'h1200, 16'h0034, 16'h1234};
        vecs[3] = '{1'b1, 3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0};
        vecs[4] = '{1'b0, 3'b011, 16'hAAAA, 16'h5555, 16'hFFFF};
        vecs[5] = '{1'b1, 3'b111, 16'h1357, 16'h0000, 16'h1357};
        vecs[6] = '{1'b0, 3'b110, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[7] = '{1'b1, 3'b011, 16'h1234, 16'h1234, 16'h0000};

        rst_n = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 1'b1, 3'b000, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        #3;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_resp_valid", 16'(resp_valid), 16'd0);
        check("rst_resp_data", resp_data, 16'h0000);
        check("rst_resp_id", 16'(resp_id), 16'd0);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_f", 16'(alu_f), 16'd0);
        check("rst_req0_ready", 16'(req0_ready), 16'd1);
        check("rst_req1_ready", 16'(req1_ready), 16'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // Contention straight after reset: requester 0 wins first
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b000, 16'hF0F0, 16'h0FF0);
        drive(1'b1, 1'b1, 3'b011, 16'hFFFF, 16'h00FF);
        resp_ready = 1'b1;
        #1;
        check("cont_req0_ready", 16'(req0_ready), 16'd1);
        check("cont_req1_ready", 16'(req1_ready), 16'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b001, 16'h0001, 16'h0002);
        check("cont_busy_req0_ready", 16'(req0_ready), 16'd0);
        check("cont_busy_req1_ready", 16'(req1_ready), 16'd0);
        wait_resp("cont_first", 16'h00F0, 1'b0);
        @(posedge clk); #1;
        // Both still valid, requester 0 was granted last
        check("cont2_req1_ready", 16'(req1_ready), 16'd1);
        check("cont2_req0_ready", 16'(req0_ready), 16'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        wait_resp("cont_second", 16'hFF00, 1'b1);
        @(posedge clk); #1;
        check("cont3_req0_ready", 16'(req0_ready), 16'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        wait_resp("cont_third", 16'h0003, 1'b0);
        @(posedge clk); #1;

        // Backpressure on a wrapping add
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b010, 16'hFFFF, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b000, 16'h5555, 16'h5555);
        drive(1'b1, 1'b1, 3'b001, 16'h1111, 16'h2222);
        wait_resp("bp", 16'h0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", c), 16'(resp_valid), 16'd1);
            check($sformatf("bp_hold_data%0d", c), resp_data, 16'h0000);
            check($sformatf("bp_hold_id%0d", c), 16'(resp_id), 16'd0);
            check($sformatf("bp_hold_rdy0_%0d", c), 16'(req0_ready), 16'd0);
            check($sformatf("bp_hold_rdy1_%0d", c), 16'(req1_ready), 16'd0);
            check_zero($sformatf("bp_hold_zero%0d", c), 16'h0000);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 16'(resp_valid), 16'd0);
        check("bp_release_busy", 16'(busy), 16'd0);

        // Reset mid-EXEC discards the operation
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 16'h0001, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        check("mid_exec_busy", 16'(busy), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_alu_a", alu_a, 16'h0000);
        check("mid_rst_valid", 16'(resp_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_valid%0d", c), 16'(resp_valid), 16'd0);
            check($sformatf("post_rst_busy%0d", c), 16'(busy), 16'd0);
        end
        run_single('{1'b0, 3'b010, 16'h0010, 16'h0020, 16'h0030}, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
